// File: rtl/pipo_rr_load_arbiter.sv
// ---------------------------------------------------------------------------
// pipo_rr_load_arbiter
//
// Shares one WIDTH-bit parallel-load register between NREQ requesters.
// In IDLE the pending requests are arbitrated round-robin. The winner's word
// is latched into pi and a one-cycle load/gnt pulse is issued. The owner then
// keeps the register for HOLD_CYCLES cycles so that consumers can sample it
// before it is written again.
//
// Ports
//   clk       in   1             clock, rising edge
//   rst       in   1             asynchronous reset, active high
//   req       in   NREQ          level request per requester
//   req_data  in   NREQ*WIDTH    requester i word at [i*WIDTH +: WIDTH]
//   gnt       out  NREQ          one-hot one-cycle accept pulse (with load)
//   load      out  1             load strobe for the shared register
//   pi        out  WIDTH         parallel-input data for the shared register
//   owner     out  $clog2(NREQ)  index of current / last owner
//   busy      out  1             high while in LOAD or HOLD
//
// All outputs come straight from flops, so there is no combinational path
// from req to any output.
// ---------------------------------------------------------------------------
module pipo_rr_load_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     load,
    output logic [WIDTH-1:0]         pi,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy
);

    localparam int OW = $clog2(NREQ);
    // The hold counter runs HOLD_CYCLES-1 down to 0, so it only needs enough
    // bits for HOLD_CYCLES-1; keep at least one bit so it is always legal.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [OW-1:0]      r_ptr;
    logic [HW-1:0]      r_hold_cnt;
    logic [NREQ-1:0]    r_gnt;
    logic               r_load;
    logic [WIDTH-1:0]   r_pi;
    logic [OW-1:0]      r_owner;
    logic               r_busy;

    // -----------------------------------------------------------------------
    // Arbitration datapath
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]   w_data [NREQ];
    logic               w_any;
    logic [OW-1:0]      w_winner;
    logic [OW:0]        w_sum;
    logic [OW-1:0]      w_ptr_next;
    logic [NREQ-1:0]    w_gnt_next;

    // Unpack the flat request data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_data[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: candidate k is (r_ptr + k) mod NREQ. The loop walks
    // offsets from the highest down, so the lowest offset with a set request
    // is the last to write w_winner and therefore wins. The sum carries one
    // extra bit so the wrap works for any NREQ, not only powers of two.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (OW+1)'(k);
            if (w_sum >= (OW+1)'(NREQ)) begin
                w_sum = w_sum - (OW+1)'(NREQ);
            end
            if (req[w_sum[OW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_sum[OW-1:0];
            end
        end
    end

    // The pointer moves to just past the winner, so the winner has the lowest
    // priority in the next arbitration.
    assign w_ptr_next = (w_winner == OW'(NREQ - 1)) ? '0 : w_winner + OW'(1);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign w_gnt_next[gi] = (w_winner == OW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Controller FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_load     <= 1'b0;
            r_pi       <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // pi and owner are written only here, so they stay stable
                    // until the next accepted request.
                    if (w_any) begin
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                        r_gnt   <= w_gnt_next;
                        r_pi    <= w_data[w_winner];
                        r_owner <= w_winner;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_ptr_next;
                    end
                end

                ST_LOAD: begin
                    r_load <= 1'b0;
                    r_gnt  <= '0;
                    if (HOLD_CYCLES > 0) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= HOLD_LAST;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    // Requests are ignored here; they are evaluated again only
                    // after the controller returns to IDLE.
                    if (r_hold_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_load  <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign load  = r_load;
    assign pi    = r_pi;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule
